// File: rtl/nand_mon_if.sv
// Snapshot channel between the NAND output edge monitor and its consumer.
// The master drives valid and the rise/fall counts; the slave drives ready.
interface nand_mon_if #(
  parameter int CNT_W = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_rise;
  logic [CNT_W-1:0] out_fall;

  modport master (output out_valid, output out_rise, output out_fall, input out_ready);
  modport slave  (input out_valid, input out_rise, input out_fall, output out_ready);
endinterface

// File: rtl/nand_out_edge_monitor.sv
// Registers the NAND2 output ZN and counts its rising/falling edges per window.
// Optional macro NAND_MON_SYNC_EN adds a 2-flop synchronizer ahead of zn_q.
module nand_out_edge_monitor #(
  parameter int CNT_W = 4,
  parameter int WIN   = 8,
  parameter int WIN_W = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_zn,
  input  logic        i_en,
  output logic        o_ovf,
  nand_mon_if.master  m_out
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);

`ifdef NAND_MON_SYNC_EN
  // Two extra sample stages: edge detection may start only once zn_prev holds real data.
  localparam int PRIME_D = 4;
  logic [1:0] r_sync;
  logic       w_zn_in;

  // Two-flop synchronizer for an asynchronous ZN source
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_zn};
    end
  end
  assign w_zn_in = r_sync[1];
`else
  localparam int PRIME_D = 2;
  logic w_zn_in;
  assign w_zn_in = i_zn;
`endif

  logic               r_zn_q;
  logic               r_zn_prev;
  logic [PRIME_D-1:0] r_prime_sr;
  logic               w_primed;
  logic               w_rise;
  logic               w_fall;
  logic               w_win_end;
  logic [CNT_W-1:0]   w_rise_nxt;
  logic [CNT_W-1:0]   w_fall_nxt;

  logic [CNT_W-1:0]   r_rise_cnt;
  logic [CNT_W-1:0]   r_fall_cnt;
  logic [WIN_W-1:0]   r_wcnt;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_out_rise;
  logic [CNT_W-1:0]   r_out_fall;
  logic               r_ovf;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Input stage: sample ZN, keep previous sample, and prime the edge detector
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_zn_q     <= 1'b0;
      r_zn_prev  <= 1'b0;
      r_prime_sr <= '0;
    end else begin
      r_zn_q     <= w_zn_in;
      r_zn_prev  <= r_zn_q;
      r_prime_sr <= {r_prime_sr[PRIME_D-2:0], 1'b1};
    end
  end

  assign w_primed = r_prime_sr[PRIME_D-1];

  // Edge detection, saturating next counts and window-end decode
  always_comb begin
    w_rise     = 1'b0;
    w_fall     = 1'b0;
    w_win_end  = 1'b0;
    w_rise_nxt = r_rise_cnt;
    w_fall_nxt = r_fall_cnt;
    if (w_primed) begin
      w_rise = r_zn_q & ~r_zn_prev;
      w_fall = ~r_zn_q & r_zn_prev;
    end else begin
      w_rise = 1'b0;
      w_fall = 1'b0;
    end
    w_rise_nxt = sat_inc(r_rise_cnt, w_rise);
    w_fall_nxt = sat_inc(r_fall_cnt, w_fall);
    w_win_end  = i_en && (r_wcnt == WIN_LAST);
  end

  // Live counters, window counter, snapshot register and sticky overflow
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rise_cnt  <= '0;
      r_fall_cnt  <= '0;
      r_wcnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_rise  <= '0;
      r_out_fall  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (i_en) begin
        if (w_win_end) begin
          r_wcnt     <= '0;
          r_rise_cnt <= '0;
          r_fall_cnt <= '0;
        end else begin
          r_wcnt     <= r_wcnt + WIN_W'(1);
          r_rise_cnt <= w_rise_nxt;
          r_fall_cnt <= w_fall_nxt;
        end
      end
      // A new snapshot may only replace the held one if the sink is free or taking it now
      if (w_win_end) begin
        if (!r_out_valid || m_out.out_ready) begin
          r_out_valid <= 1'b1;
          r_out_rise  <= w_rise_nxt;
          r_out_fall  <= w_fall_nxt;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_out_valid && m_out.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign m_out.out_valid = r_out_valid;
  assign m_out.out_rise  = r_out_rise;
  assign m_out.out_fall  = r_out_fall;
  assign o_ovf           = r_ovf;

endmodule

// File: tb/tb_nand_out_edge_monitor.sv
// Self-checking bench: vector table, directed corner sequences and random
// stimulus against a history-based reference model of the edge monitor.
module tb_nand_out_edge_monitor;
  localparam int CNT_W = 4;
  localparam int WIN   = 8;
  localparam int CMAX  = 15;
`ifdef NAND_MON_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n, zn, en;
  logic ovf8, ovf64;
  always #5 clk = ~clk;

  nand_mon_if #(.CNT_W(CNT_W)) mon8 ();
  nand_mon_if #(.CNT_W(CNT_W)) mon64 ();

  nand_out_edge_monitor #(.CNT_W(CNT_W), .WIN(8), .WIN_W(3)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_zn(zn), .i_en(en), .o_ovf(ovf8), .m_out(mon8.master));
  nand_out_edge_monitor #(.CNT_W(CNT_W), .WIN(64), .WIN_W(6)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_zn(zn), .i_en(en), .o_ovf(ovf64), .m_out(mon64.master));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: history of sampled zn values since reset release
  bit m_zh[$];
  int m_k, m_wn, m_r, m_f, m_or, m_of;
  bit m_valid, m_ovf;

  typedef struct {
    bit       zn;
    bit       en;
    bit       rdy;
    bit       ev;
    bit [3:0] er;
    bit [3:0] ef;
    bit       eovf;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit z, input bit e, input bit rdy);
    bit ev_r, ev_f, wend;
    if (!r) begin
      m_zh.delete();
      m_k = 0; m_wn = 0; m_r = 0; m_f = 0; m_or = 0; m_of = 0;
      m_valid = 1'b0; m_ovf = 1'b0;
      return;
    end
    m_zh.push_back(z);
    ev_r = 1'b0; ev_f = 1'b0; wend = 1'b0;
    if (m_k >= LAT) begin
      ev_r = m_zh[m_k-LAT+1] && !m_zh[m_k-LAT];
      ev_f = !m_zh[m_k-LAT+1] && m_zh[m_k-LAT];
    end
    m_k++;
    if (e) begin
      m_r += int'(ev_r);
      m_f += int'(ev_f);
      m_wn++;
      if (m_wn == WIN) begin
        wend = 1'b1;
        if (!m_valid || rdy) begin
          m_valid = 1'b1;
          m_or = (m_r > CMAX) ? CMAX : m_r;
          m_of = (m_f > CMAX) ? CMAX : m_f;
        end else begin
          m_ovf = 1'b1;
        end
        m_wn = 0; m_r = 0; m_f = 0;
      end
    end
    if (!wend && m_valid && rdy) m_valid = 1'b0;
  endtask

  task automatic step(input bit r, input bit z, input bit e, input bit rdy);
    logic [9:0] act, exp;
    rst_n = r; zn = z; en = e; mon8.out_ready = rdy;
    @(posedge clk);
    model_edge(r, z, e, rdy);
    #1;
    act = {mon8.out_valid, mon8.out_rise, mon8.out_fall, ovf8};
    exp = {m_valid, 4'(m_or), 4'(m_of), m_ovf};
    check("model", 32'(act), 32'(exp));
  endtask

  initial begin
    bit z;
    int last, npulse, seen, idx;
    logic [3:0] hr, hf;
    rst_n = 1'b0; zn = 1'b1; en = 1'b0;
    mon8.out_ready = 1'b0; mon64.out_ready = 1'b1;

    // Reset state and test 1 vector table: zn held high, no edges
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("reset_state", 32'({mon8.out_valid, mon8.out_rise, mon8.out_fall, ovf8}), 32'd0);
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, (i == 7), 4'd0, 4'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, tbl[i].zn, tbl[i].en, tbl[i].rdy);
      check("table", 32'({mon8.out_valid, mon8.out_rise, mon8.out_fall, ovf8}),
            32'({tbl[i].ev, tbl[i].er, tbl[i].ef, tbl[i].eovf}));
    end

    // Test 2: toggling zn, full windows give 4/4 every 8 cycles
    z = 1'b1; last = -1; npulse = 0;
    for (int i = 0; i < 40; i++) begin
      z = ~z;
      step(1'b1, z, 1'b1, 1'b1);
      if (mon8.out_valid) begin
        npulse++;
        if (i >= 10) check("toggle_split", 32'({mon8.out_rise, mon8.out_fall}), 32'h44);
        if (last >= 0) check("pulse_spacing", 32'(i - last), 32'd8);
        last = i;
      end
    end
    check("pulse_count", 32'(npulse), 32'd5);

    // Test 3: WIN=64 counters saturate at 15
    step(1'b0, 1'b0, 1'b1, 1'b1);
    seen = 0; z = 1'b0;
    for (int i = 0; i < 70; i++) begin
      z = ~z;
      step(1'b1, z, 1'b1, 1'b1);
      if (mon64.out_valid) begin
        seen++;
        check("sat64", 32'({mon64.out_rise, mon64.out_fall}), 32'hFF);
      end
    end
    check("sat64_seen", 32'(seen), 32'd1);

    // Test 4: stalled sink across two window ends
    step(1'b0, 1'b0, 1'b1, 1'b0);
    z = 1'b0; seen = 0; hr = '0; hf = '0;
    for (int i = 0; i < 17; i++) begin
      z = ~z;
      step(1'b1, z, 1'b1, 1'b0);
      if (mon8.out_valid && seen == 0) begin
        seen = 1; hr = mon8.out_rise; hf = mon8.out_fall;
      end else if (seen == 1) begin
        check("hold_stable", 32'({mon8.out_valid, mon8.out_rise, mon8.out_fall}), 32'({1'b1, hr, hf}));
      end
    end
    check("ovf_set", 32'(ovf8), 32'd1);
    z = ~z;
    step(1'b1, z, 1'b1, 1'b1);
    check("xfer_valid", 32'({mon8.out_valid, ovf8}), 32'b01);
    step(1'b1, z, 1'b1, 1'b1);
    check("ovf_sticky", 32'(ovf8), 32'd1);

    // Test 5: en low for 5 cycles delays the window end, edges then ignored
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    z = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 2) z = ~z;
      step(1'b1, z, 1'b0, 1'b0);
    end
    idx = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, z, 1'b1, 1'b0);
      if (mon8.out_valid && idx < 0) begin
        idx = i;
        check("paused_counts", 32'({mon8.out_rise, mon8.out_fall}), 32'h00);
      end
      if (idx >= 0 && i >= idx + 2) break;
    end
    check("delayed_end", 32'(idx), 32'd4);
    z = ~z;
    step(1'b1, z, 1'b1, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);
    check("mid_reset", 32'({mon8.out_valid, mon8.out_rise, mon8.out_fall, ovf8}), 32'd0);
    idx = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, z, 1'b1, 1'b0);
      if (mon8.out_valid && idx < 0) idx = i;
    end
    check("restart_window", 32'(idx), 32'd7);

    // Single step of zn exercises the input latency
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, (i >= 3), 1'b1, 1'b1);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
